// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// fetch stage (if_*) and the load/store stage (dm_*). One transaction at a
// time; data accesses win over fetches. All strobes, grants and valids come
// straight from flops so the memory port never sees a combinational glitch.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   When defined, a saturating counter tracks consecutive data grants made
//   while fetch is waiting; once it reaches STARVE_MAX, fetch wins the next
//   arbitration. When undefined, priority is strictly data-first and the
//   counter does not exist.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; requests are sampled and a winner is latched
// ISSUE  | one cycle: owner's gnt and mem_re/mem_we are high
// WAIT   | read only, MEM_LAT cycles; last cycle captures mem_rdata
// RESP   | one cycle: owner's rvalid is high

module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Latency counter is 4 bits wide, enough for MEM_LAT up to 15.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;

    logic              fetch_force;
    logic              dm_wins;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;

    // Starvation counter: counts data grants that made a waiting fetch wait
    // again; any fetch grant or a quiet fetch side resets it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_ISSUE) begin
            if (!owner_dm_q) begin
                starve_d = '0;
            end else if (if_req && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end else if ((state_q == S_IDLE) && !if_req) begin
            starve_d = '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign fetch_force = (starve_q == STARVE_LIM);
`else
    assign fetch_force = 1'b0;
`endif

    // Data wins unless fetch is being protected from starvation.
    assign dm_wins = dm_req && !(fetch_force && if_req);

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so they line up with it after the clock edge.
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dm_wins) begin
                    state_d    = S_ISSUE;
                    owner_dm_d = 1'b1;
                    we_d       = dm_we;
                    mem_addr_d = dm_addr;
                    if (dm_we) begin
                        mem_wdata_d = dm_wdata;
                    end
                    dm_gnt_d   = 1'b1;
                    mem_we_d   = dm_we;
                    mem_re_d   = !dm_we;
                end else if (if_req) begin
                    state_d    = S_ISSUE;
                    owner_dm_d = 1'b0;
                    we_d       = 1'b0;
                    mem_addr_d = if_addr;
                    if_gnt_d   = 1'b1;
                    mem_re_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (owner_dm_q) begin
                        dm_rdata_d  = mem_rdata;
                        dm_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything at once so an
    // in-flight strobe is dropped immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            we_q        <= 1'b0;
            lat_cnt_q   <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_gnt    = dm_gnt_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with MEM_LAT=1 driven by a
// vector table plus corner-case sequences, and one with MEM_LAT=3 for
// back-to-back fetch timing. Inputs change and outputs are sampled on the
// falling edge. Starvation expectations follow ARB_STARVE_GUARD_EN.

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic preload;

    // MEM_LAT = 1 instance
    logic        if_req, if_gnt, if_rvalid;
    logic [11:0] if_addr;
    logic [15:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [11:0] dm_addr;
    logic [15:0] dm_wdata, dm_rdata;
    logic        mem_re, mem_we, busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    // MEM_LAT = 3 instance
    logic        if_req_3, if_gnt_3, if_rvalid_3;
    logic [11:0] if_addr_3;
    logic [15:0] if_rdata_3;
    logic        dm_req_3, dm_we_3, dm_gnt_3, dm_rvalid_3;
    logic [11:0] dm_addr_3;
    logic [15:0] dm_wdata_3, dm_rdata_3;
    logic        mem_re_3, mem_we_3, busy_3;
    logic [11:0] mem_addr_3;
    logic [15:0] mem_wdata_3, mem_rdata_3;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .dm_req(dm_req_3), .dm_we(dm_we_3), .dm_addr(dm_addr_3), .dm_wdata(dm_wdata_3),
        .dm_gnt(dm_gnt_3), .dm_rvalid(dm_rvalid_3), .dm_rdata(dm_rdata_3),
        .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    // Memory models: data appears exactly MEM_LAT cycles after the mem_re
    // cycle; any other cycle shows a poison value.
    logic [15:0] mem1 [0:4095];
    logic [15:0] pipe1;
    logic [15:0] mem3 [0:4095];
    logic [15:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (preload) begin
            mem1[12'h010] <= 16'hA5A5;
            mem1[12'hFFF] <= 16'h0F0F;
        end else if (mem_we) begin
            mem1[mem_addr] <= mem_wdata;
        end
        pipe1 <= mem_re ? mem1[mem_addr] : 16'hDEAD;
    end
    assign mem_rdata = pipe1;

    always @(posedge clk) begin
        if (preload) begin
            mem3[12'h020] <= 16'h1111;
            mem3[12'h021] <= 16'h2222;
            mem3[12'h022] <= 16'h3333;
        end else if (mem_we_3) begin
            mem3[mem_addr_3] <= mem_wdata_3;
        end
        pipe3[0] <= mem_re_3 ? mem3[mem_addr_3] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata_3 = pipe3[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    // One complete transaction on the MEM_LAT=1 instance, checked cycle by
    // cycle from the request edge; the requester drops req on seeing gnt.
    task automatic run_txn(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        check({p, " own gnt"}, v.is_dm ? dm_gnt : if_gnt, 1);
        check({p, " other gnt"}, v.is_dm ? if_gnt : dm_gnt, 0);
        check({p, " mem_re"}, mem_re, !v.we);
        check({p, " mem_we"}, mem_we, v.we);
        check({p, " mem_addr"}, mem_addr, v.addr);
        if (v.we) check({p, " mem_wdata"}, mem_wdata, v.wdata);
        check({p, " busy issue"}, busy, 1);
        dm_req = 1'b0;
        if_req = 1'b0;
        if (v.we) begin
            @(negedge clk);
            check({p, " mem_we off"}, mem_we, 0);
            check({p, " wr no rvalid"}, dm_rvalid, 0);
            check({p, " wr idle"}, busy, 0);
        end else begin
            @(negedge clk);
            check({p, " wait strobe"}, mem_re, 0);
            check({p, " wait rvalid"}, v.is_dm ? dm_rvalid : if_rvalid, 0);
            check({p, " wait busy"}, busy, 1);
            @(negedge clk);
            check({p, " rvalid"}, v.is_dm ? dm_rvalid : if_rvalid, 1);
            check({p, " other rvalid"}, v.is_dm ? if_rvalid : dm_rvalid, 0);
            check({p, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
            @(negedge clk);
            check({p, " rvalid off"}, v.is_dm ? dm_rvalid : if_rvalid, 0);
            check({p, " rd idle"}, busy, 0);
        end
    endtask

    initial begin
        vec_t vecs [9];
        logic order [6];
        int   ng;
        logic seen;
        int   nrv;
        int   idx;
        int   rv_k [3];
        logic [15:0] rv_d [3];

        vecs[0] = '{1'b1, 1'b1, 12'h055, 16'h1234, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 12'h055, 16'h0000, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 12'h010, 16'h0000, 16'hA5A5};
        vecs[3] = '{1'b1, 1'b1, 12'h200, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 12'h200, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0F0F};
        vecs[7] = '{1'b1, 1'b1, 12'h000, 16'hFFFF, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 12'h000, 16'h0000, 16'hFFFF};

        rst = 1'b1; preload = 1'b1;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req_3 = 0; if_addr_3 = '0; dm_req_3 = 0; dm_we_3 = 0; dm_addr_3 = '0; dm_wdata_3 = '0;
        repeat (3) @(negedge clk);

        check("reset outputs", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_re, mem_we, busy}, 0);
        check("reset data", {if_rdata, dm_rdata}, 0);
        check("reset mem port", {mem_addr, mem_wdata}, 0);
        check("reset outputs lat3", {if_gnt_3, if_rvalid_3, mem_re_3, busy_3, if_rdata_3}, 0);
        preload = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);
        check("if_rdata held", if_rdata, 16'h0F0F);

        // Simultaneous requests: data first, fetch served in a later IDLE.
        @(negedge clk);
        if_req = 1; if_addr = 12'h010;
        dm_req = 1; dm_we = 0; dm_addr = 12'h200;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    check("both dm_gnt", dm_gnt, 1);
                    check("both if_gnt absent", if_gnt, 0);
                    check("both mem_addr", mem_addr, 12'h200);
                    dm_req = 0;
                end
                3: begin
                    check("both dm_rvalid", dm_rvalid, 1);
                    check("both dm_rdata", dm_rdata, 16'hBEEF);
                    check("both if_gnt t3", if_gnt, 0);
                end
                4: check("both idle t4", busy, 0);
                5: begin
                    check("both if_gnt t5", if_gnt, 1);
                    check("both if mem_addr", mem_addr, 12'h010);
                    if_req = 0;
                end
                7: begin
                    check("both if_rvalid", if_rvalid, 1);
                    check("both if_rdata", if_rdata, 16'hA5A5);
                end
                default: check($sformatf("both quiet gnt k%0d", k), {if_gnt, dm_gnt}, 0);
            endcase
        end

        // Both requests held, data side writing continuously.
        @(negedge clk);
        if_req = 1; if_addr = 12'h010;
        dm_req = 1; dm_we = 1; dm_addr = 12'h300; dm_wdata = 16'h1111;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (dm_gnt && if_gnt) check("starve single gnt", {dm_gnt, if_gnt}, 2'b10);
            if (dm_gnt) begin order[ng] = 1'b1; ng++; end
            else if (if_gnt) begin order[ng] = 1'b0; ng++; end
        end
        if_req = 0; dm_req = 0;
        check("starve grant count", ng, 6);
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
            check($sformatf("starve order %0d", g), order[g], (g == 4) ? 1'b0 : 1'b1);
`else
            check($sformatf("strict order %0d", g), order[g], 1'b1);
`endif
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = !busy;
        end
        check("starve drain idle", seen, 1);

        // Reset during the WAIT cycle of a fetch read.
        @(negedge clk);
        if_req = 1; if_addr = 12'h010;
        @(negedge clk);
        check("rstw gnt", if_gnt, 1);
        if_req = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw outputs", {if_gnt, if_rvalid, mem_re, mem_we, busy}, 0);
        check("rstw if_rdata", if_rdata, 0);
        check("rstw mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_rvalid || busy) seen = 1'b1;
        end
        check("rstw no rvalid", seen, 0);
        run_txn(100, vecs[2]);

        // Reset during ISSUE of a write drops mem_we at once.
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 12'h066; dm_wdata = 16'h7777;
        @(negedge clk);
        check("rsti mem_we before", mem_we, 1);
        dm_req = 0;
        rst = 1'b1;
        #1;
        check("rsti mem_we async", mem_we, 0);
        check("rsti gnt async", dm_gnt, 0);
        check("rsti wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rsti idle", busy, 0);

        // MEM_LAT=3: fetch held high, address advanced after each grant.
        @(negedge clk);
        if_req_3 = 1; if_addr_3 = 12'h020;
        nrv = 0; idx = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (if_rvalid_3 && nrv < 3) begin
                rv_k[nrv] = k; rv_d[nrv] = if_rdata_3; nrv++;
            end
            if (if_gnt_3) begin
                idx++;
                if (idx >= 3) if_req_3 = 0;
                else if_addr_3 = 12'h020 + 12'(idx);
            end
        end
        check("lat3 rvalid count", nrv, 3);
        if (nrv == 3) begin
            check("lat3 first rvalid", rv_k[0], 5);
            check("lat3 spacing 1", rv_k[1] - rv_k[0], 6);
            check("lat3 spacing 2", rv_k[2] - rv_k[1], 6);
            check("lat3 data 0", rv_d[0], 16'h1111);
            check("lat3 data 1", rv_d[1], 16'h2222);
            check("lat3 data 2", rv_d[2], 16'h3333);
        end
        check("lat3 idle", busy_3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
